// File: rtl/xor_alu_pkg.sv
// xor_alu_pkg: shared state encoding, counter width and key rotation helper
package xor_alu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam int CNT_W = 8;
    function automatic logic [31:0] rotl(logic [31:0] key, int w);
        return ((key << 1) | (key >> (w - 1))) & ((32'd1 << w) - 32'd1);
    endfunction
endpackage

// File: rtl/xor_unmask_if.sv
// xor_unmask_if: key load, input stream, output stream and status bundle
interface xor_unmask_if #(parameter int WIDTH = 3);
    import xor_alu_pkg::*;
    logic             key_load;
    logic [WIDTH-1:0] key_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_g;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] key_q;
    logic [CNT_W-1:0] word_cnt;
    logic             busy;
    modport slave (
        input  key_load, key_in, in_valid, in_g, out_ready,
        output in_ready, out_valid, out_a, key_q, word_cnt, busy
    );
    modport master (
        output key_load, key_in, in_valid, in_g, out_ready,
        input  in_ready, out_valid, out_a, key_q, word_cnt, busy
    );
endinterface

// File: rtl/xor_unmask_fifo.sv
// xor_unmask_fifo: shift-style sync FIFO whose head is always slot 0, so dout is a plain register
module xor_unmask_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] data [DEPTH];
    assign dout  = data[0];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // shift down on pop (never past the last valid entry, so an emptied head keeps its value) and write behind the tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && i + 1 < int'(count)) data[i] <= data[(i + 1) % DEPTH];
                if (push && i == int'(count) - int'(pop)) data[i] <= din;
            end
        end
    end
endmodule

// File: rtl/xor_unmask.sv
// xor_unmask: recovers a = g ^ key from a stream, with rolling key and flush-before-rekey
module xor_unmask
    import xor_alu_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int DEPTH      = 2,
    parameter int KEY_ROTATE = 1
) (
    input  logic         clk,
    input  logic         rst,
    xor_unmask_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    state_t           state;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] pend;
    logic [CNT_W-1:0] word_cnt;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic             drained;
    logic [WIDTH-1:0] key_rot;
    xor_unmask_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (bus.in_g ^ key_q),
        .pop   (pop),
        .dout  (bus.out_a),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    assign bus.in_ready  = state == RUN && !full;
    assign bus.out_valid = !empty;
    assign bus.busy      = state == FLUSH;
    assign bus.key_q     = key_q;
    assign bus.word_cnt  = word_cnt;
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = !empty && bus.out_ready;
    assign drained       = empty || (count == CW'(1) && pop);
    assign key_rot       = KEY_ROTATE != 0 ? WIDTH'(rotl(32'(key_q), WIDTH)) : key_q;
    // control FSM: the key only switches once every word encoded under the old key has left the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            key_q    <= '0;
            pend     <= '0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.key_load) begin
                    key_q <= bus.key_in;
                    state <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        word_cnt <= word_cnt + 1'b1;
                        key_q    <= key_rot;
                    end
                    if (bus.key_load) begin
                        pend  <= bus.key_in;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (bus.key_load) pend <= bus.key_in;
                    if (drained) begin
                        key_q <= bus.key_load ? bus.key_in : pend;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_unmask.sv
// tb_xor_unmask: static-key and rolling-key instances driven alike, checked against a queue model
module tb_xor_unmask;
    import xor_alu_pkg::*;
    logic       clk = 0;
    logic       rst = 0;
    logic       key_load = 0;
    logic [2:0] key_in = 0;
    logic [2:0] in_g = 0;
    logic       in_valid = 0;
    logic       out_ready = 0;
    int total = 0;
    int bad = 0;
    int m_state [2];
    int m_key [2];
    int m_pend [2];
    int m_cnt [2];
    int m_last [2];
    int mq [2][$];

    xor_unmask_if #(.WIDTH(3)) b0 ();
    xor_unmask_if #(.WIDTH(3)) b1 ();
    assign b0.key_load  = key_load;
    assign b0.key_in    = key_in;
    assign b0.in_valid  = in_valid;
    assign b0.in_g      = in_g;
    assign b0.out_ready = out_ready;
    assign b1.key_load  = key_load;
    assign b1.key_in    = key_in;
    assign b1.in_valid  = in_valid;
    assign b1.in_g      = in_g;
    assign b1.out_ready = out_ready;

    xor_unmask #(.WIDTH(3), .DEPTH(2), .KEY_ROTATE(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    xor_unmask #(.WIDTH(3), .DEPTH(2), .KEY_ROTATE(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int r = 0; r < 2; r++) begin
            m_state[r] = 0;
            m_key[r]   = 0;
            m_pend[r]  = 0;
            m_cnt[r]   = 0;
            m_last[r]  = 0;
            mq[r].delete();
        end
    endtask

    task automatic cmp_inst(int r, logic ir, logic ov, logic [2:0] oa, logic [2:0] kq, logic [7:0] wc, logic bz);
        int n = mq[r].size();
        check($sformatf("u%0d in_ready", r), 32'(ir), 32'(m_state[r] == 1 && n < 2));
        check($sformatf("u%0d out_valid", r), 32'(ov), 32'(n > 0));
        check($sformatf("u%0d out_a", r), 32'(oa), n > 0 ? mq[r][0] : m_last[r]);
        check($sformatf("u%0d key_q", r), 32'(kq), m_key[r]);
        check($sformatf("u%0d word_cnt", r), 32'(wc), m_cnt[r]);
        check($sformatf("u%0d busy", r), 32'(bz), 32'(m_state[r] == 2));
    endtask

    task automatic mstep(int r);
        bit acc = in_valid && m_state[r] == 1 && mq[r].size() < 2;
        if (out_ready && mq[r].size() > 0) m_last[r] = mq[r].pop_front();
        case (m_state[r])
            0: if (key_load) begin
                m_key[r] = key_in;
                m_state[r] = 1;
            end
            1: begin
                if (acc) begin
                    mq[r].push_back(int'(in_g) ^ m_key[r]);
                    m_cnt[r] = (m_cnt[r] + 1) % 256;
                    if (r == 1) m_key[r] = (m_key[r] * 2) % 8 + m_key[r] / 4;
                end
                if (key_load) begin
                    m_pend[r] = key_in;
                    m_state[r] = 2;
                end
            end
            default: begin
                if (key_load) m_pend[r] = key_in;
                if (mq[r].size() == 0) begin
                    m_key[r] = m_pend[r];
                    m_state[r] = 1;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_inst(0, b0.in_ready, b0.out_valid, b0.out_a, b0.key_q, b0.word_cnt, b0.busy);
        cmp_inst(1, b1.in_ready, b1.out_valid, b1.out_a, b1.key_q, b1.word_cnt, b1.busy);
        mstep(0);
        mstep(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        mreset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        tick();
        // static and rolling key
        key_load = 1; key_in = 3'b011; tick(); key_load = 0;
        in_valid = 1; out_ready = 1;
        in_g = 3'b010; tick();
        check("static w0", 32'(b0.out_a), 1);
        check("roll w0", 32'(b1.out_a), 1);
        check("roll key1", 32'(b1.key_q), 6);
        in_g = 3'b100; tick();
        check("static w1", 32'(b0.out_a), 7);
        check("roll w1", 32'(b1.out_a), 2);
        check("roll key2", 32'(b1.key_q), 5);
        in_g = 3'b000; tick();
        check("static w2", 32'(b0.out_a), 3);
        in_valid = 0; tick();
        check("static cnt", 32'(b0.word_cnt), 3);
        // backpressure: only two fit
        out_ready = 0; in_valid = 1;
        repeat (4) begin in_g = 3'($urandom); tick(); end
        check("bp cnt", 32'(b0.word_cnt), 5);
        check("bp in_ready", 32'(b0.in_ready), 0);
        in_valid = 0; out_ready = 1; tick(); tick();
        check("bp drained", 32'(b0.out_valid), 0);
        // key change with buffered words
        out_ready = 0; in_valid = 1; tick(); tick(); in_valid = 0;
        key_load = 1; key_in = 3'b101; tick(); key_load = 0;
        check("flush busy", 32'(b0.busy), 1);
        check("flush in_ready", 32'(b0.in_ready), 0);
        out_ready = 1; tick();
        check("flush busy2", 32'(b0.busy), 1);
        tick();
        check("new key", 32'(b0.key_q), 5);
        check("run again", 32'(b0.busy), 0);
        in_valid = 1; in_g = 3'b101; tick(); in_valid = 0;
        check("new key w static", 32'(b0.out_a), 0);
        check("new key w roll", 32'(b1.out_a), 0);
        tick();
        // async reset between edges with a full FIFO
        out_ready = 0; in_valid = 1; tick(); tick(); in_valid = 0;
        #3 rst = 0;
        #2;
        check("ar out_valid", 32'(b0.out_valid), 0);
        check("ar word_cnt", 32'(b0.word_cnt), 0);
        check("ar key_q", 32'(b1.key_q), 0);
        check("ar in_ready", 32'(b1.in_ready), 0);
        mreset();
        @(posedge clk);
        #3 rst = 1;
        @(posedge clk);
        #1;
        in_valid = 1; tick(); tick(); in_valid = 0;
        check("idle ignore", 32'(b0.word_cnt), 0);
        // counter wrap with continuous flow
        key_load = 1; key_in = 3'($urandom); tick(); key_load = 0;
        in_valid = 1; out_ready = 1;
        repeat (256) begin in_g = 3'($urandom); tick(); end
        in_valid = 0;
        check("wrap static", 32'(b0.word_cnt), 0);
        check("wrap roll", 32'(b1.word_cnt), 0);
        tick();
        // random traffic
        repeat (400) begin
            in_valid  = ($urandom % 8) != 0;
            out_ready = ($urandom % 4) != 0;
            key_load  = ($urandom % 40) == 0;
            key_in    = 3'($urandom);
            in_g      = 3'($urandom);
            tick();
        end
        key_load = 0; in_valid = 0; out_ready = 1;
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
